// File: rtl/reg_load_demux.sv
// reg_load_demux: four-register bank with decoded load enable; q3 doubles as a self-incrementing PC.
module reg_load_demux #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ld_en,
   input  logic [1:0]       ld_sel,
   input  logic [WIDTH-1:0] d,
   input  logic             pc_inc_en,
   output logic [3:0]       ld_onehot,
   output logic [WIDTH-1:0] q0,
   output logic [WIDTH-1:0] q1,
   output logic [WIDTH-1:0] q2,
   output logic [WIDTH-1:0] q3,
   output logic             pc_wrap,
   output logic             ld_ack,
   output logic [1:0]       ld_ack_sel
);
   logic inc;
   always_comb begin
      ld_onehot = ld_en ? 4'b0001 << ld_sel : 4'b0000;
      inc = pc_inc_en && !ld_onehot[3];
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         q0 <= '0;
         q1 <= '0;
         q2 <= '0;
         q3 <= '0;
         pc_wrap <= 1'b0;
         ld_ack <= 1'b0;
         ld_ack_sel <= 2'b00;
      end else begin
         if (ld_onehot[0]) q0 <= d;
         if (ld_onehot[1]) q1 <= d;
         if (ld_onehot[2]) q2 <= d;
         q3 <= ld_onehot[3] ? d : inc ? q3 + 1'b1 : q3;
         pc_wrap <= inc && (&q3);
         ld_ack <= ld_en;
         if (ld_en) ld_ack_sel <= ld_sel;
      end
   end
endmodule

// File: tb/tb_reg_load_demux.sv
// tb_reg_load_demux: directed self-checking bench for reg_load_demux.
module tb_reg_load_demux;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ld_en = 1'b0;
   logic [1:0] ld_sel = 2'b00;
   logic [3:0] d = 4'h0;
   logic       pc_inc_en = 1'b0;
   logic [3:0] ld_onehot;
   logic [3:0] q0, q1, q2, q3;
   logic       pc_wrap, ld_ack;
   logic [1:0] ld_ack_sel;
   int         errors = 0;
   int         checks = 0;

   reg_load_demux #(.WIDTH(4)) dut (
      .clk(clk), .rst(rst), .ld_en(ld_en), .ld_sel(ld_sel), .d(d),
      .pc_inc_en(pc_inc_en), .ld_onehot(ld_onehot),
      .q0(q0), .q1(q1), .q2(q2), .q3(q3),
      .pc_wrap(pc_wrap), .ld_ack(ld_ack), .ld_ack_sel(ld_ack_sel)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; ld_en = 1'b0; pc_inc_en = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; ld_en = 1'b1; ld_sel = 2'b01; d = 4'hA; pc_inc_en = 1'b1;
      tick();
      tick();
      checks++;
      if ({q0, q1, q2, q3} !== 16'h0000) begin
         errors++; $display("FAIL reset_q got=%h exp=0000", {q0, q1, q2, q3});
      end
      checks++;
      if ({pc_wrap, ld_ack, ld_ack_sel} !== 4'b0000) begin
         errors++; $display("FAIL reset_flags got=%b exp=0000", {pc_wrap, ld_ack, ld_ack_sel});
      end
      rst = 1'b0; ld_en = 1'b0; pc_inc_en = 1'b0;
   endtask

   task automatic test_decoded_loads();
      logic [3:0] vals [3] = '{4'h3, 4'h5, 4'hC};
      logic [3:0] oh   [3] = '{4'b0001, 4'b0010, 4'b0100};
      do_reset();
      for (int i = 0; i < 3; i++) begin
         ld_en = 1'b1; ld_sel = 2'(i); d = vals[i];
         #1;
         checks++;
         if (ld_onehot !== oh[i]) begin
            errors++; $display("FAIL onehot_%0d got=%b exp=%b", i, ld_onehot, oh[i]);
         end
         tick();
         checks++;
         if ({ld_ack, ld_ack_sel} !== {1'b1, 2'(i)}) begin
            errors++; $display("FAIL ack_%0d got=%b exp=%b", i, {ld_ack, ld_ack_sel}, {1'b1, 2'(i)});
         end
      end
      ld_en = 1'b0;
      #1;
      checks++;
      if (ld_onehot !== 4'b0000) begin
         errors++; $display("FAIL onehot_idle got=%b exp=0000", ld_onehot);
      end
      tick();
      checks++;
      if ({q0, q1, q2, q3} !== 16'h35C0) begin
         errors++; $display("FAIL loads_q got=%h exp=35c0", {q0, q1, q2, q3});
      end
      checks++;
      if ({ld_ack, ld_ack_sel} !== 3'b010) begin
         errors++; $display("FAIL ack_drop got=%b exp=010", {ld_ack, ld_ack_sel});
      end
   endtask

   task automatic test_pc_wrap();
      do_reset();
      pc_inc_en = 1'b1;
      for (int k = 1; k <= 17; k++) begin
         tick();
         checks++;
         if ({q3, pc_wrap} !== {4'(k % 16), k == 16}) begin
            errors++; $display("FAIL pc_step_%0d got q3=%h wrap=%b exp q3=%h wrap=%b",
                               k, q3, pc_wrap, 4'(k % 16), k == 16);
         end
      end
      pc_inc_en = 1'b0;
   endtask

   task automatic test_load_vs_inc();
      do_reset();
      ld_en = 1'b1; ld_sel = 2'b11; d = 4'h7;
      #1;
      checks++;
      if (ld_onehot !== 4'b1000) begin
         errors++; $display("FAIL onehot_3 got=%b exp=1000", ld_onehot);
      end
      tick();
      d = 4'hF; pc_inc_en = 1'b1;
      tick();
      checks++;
      if ({q3, pc_wrap, ld_ack} !== {4'hF, 1'b0, 1'b1}) begin
         errors++; $display("FAIL load_wins got q3=%h wrap=%b ack=%b exp q3=f wrap=0 ack=1", q3, pc_wrap, ld_ack);
      end
      ld_en = 1'b0;
      tick();
      checks++;
      if ({q3, pc_wrap, ld_ack, ld_ack_sel} !== {4'h0, 1'b1, 1'b0, 2'b11}) begin
         errors++; $display("FAIL wrap_after_load got q3=%h wrap=%b ack=%b sel=%b exp q3=0 wrap=1 ack=0 sel=11",
                            q3, pc_wrap, ld_ack, ld_ack_sel);
      end
      pc_inc_en = 1'b0;
      tick();
      checks++;
      if ({q3, pc_wrap} !== {4'h0, 1'b0}) begin
         errors++; $display("FAIL wrap_pulse_end got q3=%h wrap=%b exp q3=0 wrap=0", q3, pc_wrap);
      end
   endtask

   task automatic test_concurrent();
      do_reset();
      ld_en = 1'b1;
      ld_sel = 2'b00; d = 4'h1; tick();
      ld_sel = 2'b10; d = 4'h6; tick();
      ld_sel = 2'b11; d = 4'h2; tick();
      ld_sel = 2'b01; d = 4'h9; pc_inc_en = 1'b1;
      tick();
      checks++;
      if ({q0, q1, q2, q3} !== 16'h1963) begin
         errors++; $display("FAIL concurrent_q got=%h exp=1963", {q0, q1, q2, q3});
      end
      checks++;
      if ({ld_ack, ld_ack_sel, pc_wrap} !== 4'b1010) begin
         errors++; $display("FAIL concurrent_flags got=%b exp=1010", {ld_ack, ld_ack_sel, pc_wrap});
      end
      ld_en = 1'b0; pc_inc_en = 1'b0;
   endtask

   task automatic test_back_to_back();
      ld_en = 1'b1; ld_sel = 2'b10; d = 4'hA;
      tick();
      checks++;
      if (q2 !== 4'hA) begin
         errors++; $display("FAIL b2b_first got=%h exp=a", q2);
      end
      d = 4'hB;
      tick();
      checks++;
      if ({q2, ld_ack, ld_ack_sel} !== {4'hB, 1'b1, 2'b10}) begin
         errors++; $display("FAIL b2b_second got=%h exp=%h", {q2, ld_ack, ld_ack_sel}, {4'hB, 1'b1, 2'b10});
      end
      ld_en = 1'b0;
      tick();
   endtask

   task automatic test_idle();
      logic [15:0] held;
      logic [1:0]  sel_held;
      held = {q0, q1, q2, q3};
      sel_held = ld_ack_sel;
      ld_en = 1'b0; pc_inc_en = 1'b0;
      for (int i = 0; i < 6; i++) begin
         ld_sel = 2'($urandom_range(3)); d = 4'($urandom_range(15));
         #1;
         checks++;
         if (ld_onehot !== 4'b0000) begin
            errors++; $display("FAIL idle_onehot_%0d got=%b exp=0000", i, ld_onehot);
         end
         tick();
         checks++;
         if ({q0, q1, q2, q3, ld_ack, ld_ack_sel} !== {held, 1'b0, sel_held}) begin
            errors++; $display("FAIL idle_hold_%0d got=%h exp=%h", i,
                               {q0, q1, q2, q3, ld_ack, ld_ack_sel}, {held, 1'b0, sel_held});
         end
      end
   endtask

   task automatic test_reset_mid_op();
      rst = 1'b1; ld_en = 1'b1; ld_sel = 2'b00; d = 4'hF; pc_inc_en = 1'b1;
      tick();
      checks++;
      if ({q0, q1, q2, q3, pc_wrap, ld_ack, ld_ack_sel} !== 20'h0) begin
         errors++; $display("FAIL reset_mid_op got=%h exp=00000", {q0, q1, q2, q3, pc_wrap, ld_ack, ld_ack_sel});
      end
      rst = 1'b0; ld_en = 1'b0; pc_inc_en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_decoded_loads();
      test_pc_wrap();
      test_load_vs_inc();
      test_concurrent();
      test_back_to_back();
      test_idle();
      test_reset_mid_op();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
